imem_uart_loader: RTL
=====================

Name: imem_uart_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory.
- Receives a program image over a UART RX line and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory through a dedicated write port.
- Holds the CPU core in reset until the full image has been written.
- Lets new programs load without resynthesising the memory init file.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
ADDR_W, 10, instruction memory word-address width; capacity = 2^ADDR_W words

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, asynchronous, active-high
uart_rx  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk
wr_en  out  1  one-cycle write strobe to instruction memory
wr_addr  out  ADDR_W  word address of the current write
wr_data  out  32  instruction word to write
cpu_hold  out  1  high = CPU core held in reset; drives the CPU's rst
done  out  1  image fully loaded (sticky until rst)
err  out  1  load aborted (sticky until rst)

Behaviour:
Reset values:
- wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0.
- Byte counter, bit counter and baud counter all 0; loader FSM in LEN_LO; RX FSM in IDLE.

RX front end:
- uart_rx passes through a 2-FF synchroniser; both FFs reset to 1.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on synchronised falling edge.
- START: at CLKS_PER_BIT/2 clocks, resample the line.
  - Line low: go to DATA and reset the baud counter.
  - Line high: treat as a glitch and return to IDLE; no error.
- DATA: sample every CLKS_PER_BIT clocks, 8 samples, shifted LSB first.
- STOP: sample once after CLKS_PER_BIT.
  - High: assert internal byte_valid for exactly 1 cycle, go to IDLE.
  - Low: raise a framing error.

Loader FSM:
- States: LEN_LO, LEN_HI, WORD, DONE, ERROR.
- LEN_LO: on byte_valid, latch len[7:0]; go to LEN_HI.
- LEN_HI: on byte_valid, latch len[15:8].
  - len==0 or len>2^ADDR_W: go to ERROR.
  - Otherwise go to WORD with byte index 0.
- WORD: on byte_valid, place byte k (k=0..3) into word bits [8k+7:8k].
  - Fourth byte: in the next cycle drive wr_en=1 for 1 cycle with wr_data = assembled word and wr_addr = current address.
  - In the cycle after the strobe, wr_addr increments and the words-written counter increments.
  - When the counter reaches len: go to DONE.
- DONE: done=1 and cpu_hold=0 from the first cycle in DONE. All further RX bytes are ignored; no writes.
- ERROR: err=1 and cpu_hold stays 1. No further writes; remains here until rst.
- A framing error in any state except DONE forces ERROR.

Rules and boundaries:
- Latency: wr_en rises exactly 2 clk after the 4th byte's stop-bit sample.
- wr_en is never asserted in LEN_LO, LEN_HI, DONE or ERROR.
- At most one wr_en per 4 received bytes.
- wr_addr never exceeds len-1; with len = 2^ADDR_W, the last write is at address 2^ADDR_W-1 and there is no wrap.
- rst asserted mid-byte or mid-word discards the partial byte/word. All state returns to reset values, cpu_hold returns high immediately (asynchronously), and the next load restarts at address 0.
- A byte_valid arriving in the same cycle as the wr_en strobe cannot occur, because bytes are at least 10*CLKS_PER_BIT clocks apart. No arbitration is required.
- The CPU's instruction memory read port is unused while cpu_hold=1, so no read/write collision handling is needed.

Test Plan:
Bench uses CLK_HZ=1600, BAUD=100 (CLKS_PER_BIT=16), ADDR_W=4.
1. Nominal load: send len=0x0002, then 13 05 00 00 93 05 10 00 -> wr_en pulses twice: addr 0 data 0x00000513, addr 1 data 0x00100593. done=1 and cpu_hold=0 after the 2nd write; err=0.
2. Zero / oversize length: len=0x0000 -> err=1, cpu_hold=1, no wr_en. After rst, len=0x0011 (17 > 16) -> same response.
3. Framing error: stop bit driven low on the 3rd data byte -> err=1, no wr_en at any point, cpu_hold stays 1.
4. Glitch: 4-clock low pulse on idle line (shorter than half a bit), then a normal load of len=1 word 0xDEADBEEF -> exactly one write, addr 0 data 0xDEADBEEF.
5. Reset mid-load: rst asserted after 2 bytes of word 0, then a full len=1 load of 0x12345678 -> single write at addr 0 with 0x12345678; cpu_hold high throughout until done.
6. Capacity and post-done traffic: len=16 with words 0..15 -> last write at addr 15, no wrap, done=1. Eight further bytes sent -> no wr_en, outputs unchanged.

Source files
------------

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program image over UART (8N1), packs
// little-endian 32-bit words into instruction memory and holds the CPU until done.
module imem_uart_loader #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam int CPB   = CLK_HZ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [16:0] CAP = 17'(1 << ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, WORD, DONE, ERROR} ld_state_t;

  rx_state_t        rx_state, rx_next;
  ld_state_t        ld_state, ld_next;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;
  logic             half_tick, bit_tick;

  assign half_tick = (baud_cnt == CNT_W'(HALF - 1));
  assign bit_tick  = (baud_cnt == CNT_W'(CPB - 1));

  // ---------------- RX front end ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        RX_START: baud_cnt <= half_tick ? '0 : baud_cnt + 1'b1;
        RX_DATA: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            if (rx_s2) byte_valid <= 1'b1;
            else       frame_err  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: baud_cnt <= '0;
      endcase
    end
  end

  // ---------------- Loader ----------------
  logic [15:0]   len, len_full, cnt_nxt;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;
  logic          wr_pend, last_wr, len_bad;
  logic [ADDR_W:0] wr_cnt;

  assign len_full = {rx_shift, len[7:0]};
  assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > CAP);
  assign cnt_nxt  = 16'(wr_cnt) + 16'd1;
  assign last_wr  = (cnt_nxt == len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ld_state <= LEN_LO;
    else     ld_state <= ld_next;
  end

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LEN_LO:  if (byte_valid) ld_next = LEN_HI;
      LEN_HI:  if (byte_valid) ld_next = len_bad ? ERROR : WORD;
      WORD:    if (wr_en && last_wr) ld_next = DONE;
      DONE:    ld_next = DONE;
      ERROR:   ld_next = ERROR;
      default: ld_next = LEN_LO;
    endcase
    // once loaded, line noise must not revoke the running program
    if (frame_err && ld_state != DONE) ld_next = ERROR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      wr_pend  <= 1'b0;
      wr_cnt   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      case (ld_state)
        LEN_LO: if (byte_valid) len[7:0] <= rx_shift;
        LEN_HI: begin
          if (byte_valid) len[15:8] <= rx_shift;
          byte_idx <= '0;
        end
        WORD: begin
          if (byte_valid) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= rx_shift;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) wr_pend <= 1'b1;
          end
          if (wr_pend) begin
            wr_pend <= 1'b0;
            wr_en   <= 1'b1;
            wr_data <= word_buf;
          end
          // last address is held so a full-capacity image never wraps to 0
          if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (!last_wr) wr_addr <= wr_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_hold = (ld_state != DONE);
  assign done     = (ld_state == DONE);
  assign err      = (ld_state == ERROR);
endmodule
